// File: rtl/rv32_wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// rv32_wb_port_arbiter
//
// Purpose:
//   Shares the single register-file write port between the in-order writeback
//   stage and long-latency unit (MUL/DIV) results. Writeback always wins the
//   port. LU results are queued in a small FIFO and drained, in arrival order,
//   into cycles where writeback does not write. A starvation counter raises
//   stall_req so the frontend can insert a writeback bubble. A pending
//   destination lookup (pend_hit) lets decode detect RAW/WAW hazards against
//   results that are still buffered.
//
// Optional feature (compile-time macro RV32_WB_ARB_BYPASS_EN):
//   When defined, an LU result arriving while the FIFO is empty and writeback
//   is idle is written through the port in the same cycle instead of being
//   queued. When undefined, every LU result goes through the FIFO and the
//   minimum acceptance-to-write latency is one cycle.
//
// Parameters:
//   DEPTH         LU result FIFO entries (power of two, >= 2)
//   STARVE_LIMIT  consecutive non-drain cycles with a non-empty FIFO before
//                 stall_req asserts (>= 1)
//
// Ports:
//   clk, rst                              clock, asynchronous active-high reset
//   pipe_reg_write, pipe_rd, pipe_wb_data writeback stage write request
//   lu_valid, lu_ready, lu_rd, lu_data    LU result handshake
//   reg_write, rd, wb_data                register file write port
//   stall_req                             bubble request to the frontend
//   query_rs1, query_rs2, query_rd        decode registers to look up
//   pend_hit                              a query matches a buffered result
//
// Handshake: an LU result transfers at a rising clk edge where lu_valid and
//   lu_ready are both 1. lu_ready depends only on registered occupancy, never
//   on lu_valid or on the same-cycle drain, so a full FIFO refuses a result
//   even in the cycle its head is drained.
// -----------------------------------------------------------------------------
module rv32_wb_port_arbiter #(
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pipe_reg_write,
   input  logic [4:0]  pipe_rd,
   input  logic [31:0] pipe_wb_data,
   input  logic        lu_valid,
   output logic        lu_ready,
   input  logic [4:0]  lu_rd,
   input  logic [31:0] lu_data,
   output logic        reg_write,
   output logic [4:0]  rd,
   output logic [31:0] wb_data,
   output logic        stall_req,
   input  logic [4:0]  query_rs1,
   input  logic [4:0]  query_rs2,
   input  logic [4:0]  query_rd,
   output logic        pend_hit
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   // FIFO storage; contents need no reset because occupancy qualifies them.
   logic [4:0]    rd_mem_q   [DEPTH];
   logic [31:0]   data_mem_q [DEPTH];

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [SW-1:0] starve_q, starve_d;
   logic          stall_q, stall_d;

   logic          pipe_wr_eff;
   logic          fifo_nempty;
   logic          deq;
   logic          enq;
   logic          bypass;

   logic [PW-1:0] ent_off   [DEPTH];
   logic [DEPTH-1:0] ent_valid;

   assign pipe_wr_eff = pipe_reg_write && (pipe_rd != 5'd0);
   assign fifo_nempty = (count_q != '0);

   // Gated by rst so the LU sees no acceptance while reset is held.
   assign lu_ready  = !rst && (count_q < CW'(DEPTH));
   assign stall_req = stall_q;

   // A handshake with lu_rd == 0 completes but creates no entry; a bypassed
   // result is consumed directly by the port.
   assign enq = lu_valid && lu_ready && (lu_rd != 5'd0) && !bypass;

   // -----------------------------------------------------------------------
   // Write port mux: writeback, then FIFO head, then (optionally) bypass.
   // -----------------------------------------------------------------------
   always_comb begin
      reg_write = 1'b0;
      rd        = 5'd0;
      wb_data   = 32'd0;
      deq       = 1'b0;
      bypass    = 1'b0;
      if (!rst) begin
         if (pipe_wr_eff) begin
            reg_write = 1'b1;
            rd        = pipe_rd;
            wb_data   = pipe_wb_data;
         end else if (fifo_nempty) begin
            reg_write = 1'b1;
            rd        = rd_mem_q[rd_ptr_q];
            wb_data   = data_mem_q[rd_ptr_q];
            deq       = 1'b1;
         end
`ifdef RV32_WB_ARB_BYPASS_EN
         else if (lu_valid && (lu_rd != 5'd0)) begin
            reg_write = 1'b1;
            rd        = lu_rd;
            wb_data   = lu_data;
            bypass    = 1'b1;
         end
`endif
      end
   end

   // -----------------------------------------------------------------------
   // Next-state: pointers, occupancy, starvation counter.
   // -----------------------------------------------------------------------
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (enq) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (deq) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({enq, deq})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Counts cycles in which something is buffered but the port is taken by
   // writeback; saturates so stall_req holds until a drain actually happens.
   always_comb begin
      starve_d = starve_q;
      if (!fifo_nempty || deq) begin
         starve_d = '0;
      end else if (starve_q != SW'(STARVE_LIMIT)) begin
         starve_d = starve_q + SW'(1);
      end
      stall_d = (starve_d == SW'(STARVE_LIMIT));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         starve_q <= '0;
         stall_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         starve_q <= starve_d;
         stall_q  <= stall_d;
      end
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         rd_mem_q[wr_ptr_q]   <= lu_rd;
         data_mem_q[wr_ptr_q] <= lu_data;
      end
   end

   // -----------------------------------------------------------------------
   // Pending-destination lookup. Entry i is live when its distance from the
   // read pointer (modulo DEPTH) is below the occupancy.
   // -----------------------------------------------------------------------
   always_comb begin
      ent_valid = '0;
      for (int i = 0; i < DEPTH; i++) begin
         ent_off[i]   = PW'(i) - rd_ptr_q;
         ent_valid[i] = (CW'(ent_off[i]) < count_q);
      end
   end

   always_comb begin
      pend_hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ent_valid[i]) begin
            if (((query_rs1 != 5'd0) && (rd_mem_q[i] == query_rs1)) ||
                ((query_rs2 != 5'd0) && (rd_mem_q[i] == query_rs2)) ||
                ((query_rd  != 5'd0) && (rd_mem_q[i] == query_rd))) begin
               pend_hit = 1'b1;
            end
         end
      end
      if (rst) begin
         pend_hit = 1'b0;
      end
   end

endmodule

// File: tb/tb_rv32_wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rv32_wb_port_arbiter
//
// Bench for rv32_wb_port_arbiter (DEPTH=4, STARVE_LIMIT=8). Expected LU writes
// are queued in exp_q when a result is handed over and popped when the port
// drains it; a hand-derived vector table plus directed sequences cover
// starvation, full-FIFO refusal, drain ordering and reset flush.
// Honours RV32_WB_ARB_BYPASS_EN for the expected write-through behaviour.
// -----------------------------------------------------------------------------
module tb_rv32_wb_port_arbiter;

   localparam int DEPTH = 4;
   localparam int LIMIT = 8;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   always #5 clk = ~clk;

   logic        pipe_reg_write;
   logic [4:0]  pipe_rd;
   logic [31:0] pipe_wb_data;
   logic        lu_valid;
   logic        lu_ready;
   logic [4:0]  lu_rd;
   logic [31:0] lu_data;
   logic        reg_write;
   logic [4:0]  rd;
   logic [31:0] wb_data;
   logic        stall_req;
   logic [4:0]  query_rs1;
   logic [4:0]  query_rs2;
   logic [4:0]  query_rd;
   logic        pend_hit;

   rv32_wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
      .clk            (clk),
      .rst            (rst),
      .pipe_reg_write (pipe_reg_write),
      .pipe_rd        (pipe_rd),
      .pipe_wb_data   (pipe_wb_data),
      .lu_valid       (lu_valid),
      .lu_ready       (lu_ready),
      .lu_rd          (lu_rd),
      .lu_data        (lu_data),
      .reg_write      (reg_write),
      .rd             (rd),
      .wb_data        (wb_data),
      .stall_req      (stall_req),
      .query_rs1      (query_rs1),
      .query_rs2      (query_rs2),
      .query_rd       (query_rd),
      .pend_hit       (pend_hit)
   );

   // ---------------- scoreboard ----------------
   logic [36:0] exp_q[$];   // {rd, data} of accepted, not yet drained results
   int          starve_m;
   int          tests;
   int          fails;

   logic        obs_we;
   logic [4:0]  obs_rd;
   logic [31:0] obs_data;
   logic        obs_rdy;
   logic        obs_hit;
   logic        obs_stall;

   typedef struct {
      logic        pwe;
      logic [4:0]  prd;
      logic [31:0] pdata;
      logic        lv;
      logic [4:0]  lrd;
      logic [31:0] ldata;
      logic [4:0]  q1;
      logic [4:0]  q2;
      logic [4:0]  qd;
      logic        e_we;
      logic [4:0]  e_rd;
      logic [31:0] e_data;
      logic        e_rdy;
      logic        e_hit;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_idle();
      pipe_reg_write = 1'b0;
      pipe_rd        = 5'd0;
      pipe_wb_data   = 32'd0;
      lu_valid       = 1'b0;
      lu_rd          = 5'd0;
      lu_data        = 32'd0;
      query_rs1      = 5'd0;
      query_rs2      = 5'd0;
      query_rd       = 5'd0;
   endtask

   // One clock cycle: drive just after posedge, check at negedge, update the
   // scoreboard, and return just after the next posedge.
   task automatic cycle(input logic pwe, input logic [4:0] prd, input logic [31:0] pdata,
                        input logic lv, input logic [4:0] lrd, input logic [31:0] ldata,
                        input logic [4:0] q1, input logic [4:0] q2, input logic [4:0] qd);
      logic        e_we;
      logic [4:0]  e_rd;
      logic [31:0] e_data;
      logic        e_rdy;
      logic        e_hit;
      logic        e_stall;
      logic        drain;
      logic        byp;
      logic [4:0]  ent_rd;
      pipe_reg_write = pwe;
      pipe_rd        = prd;
      pipe_wb_data   = pdata;
      lu_valid       = lv;
      lu_rd          = lrd;
      lu_data        = ldata;
      query_rs1      = q1;
      query_rs2      = q2;
      query_rd       = qd;

      e_rdy   = (exp_q.size() < DEPTH);
      e_stall = (starve_m == LIMIT);
      drain   = 1'b0;
      byp     = 1'b0;
      e_we    = 1'b0;
      e_rd    = 5'd0;
      e_data  = 32'd0;
      if (pwe && prd != 5'd0) begin
         e_we = 1'b1; e_rd = prd; e_data = pdata;
      end else if (exp_q.size() > 0) begin
         e_we = 1'b1; e_rd = exp_q[0][36:32]; e_data = exp_q[0][31:0]; drain = 1'b1;
      end
`ifdef RV32_WB_ARB_BYPASS_EN
      else if (lv && lrd != 5'd0) begin
         e_we = 1'b1; e_rd = lrd; e_data = ldata; byp = 1'b1;
      end
`endif
      e_hit = 1'b0;
      foreach (exp_q[k]) begin
         ent_rd = exp_q[k][36:32];
         if ((q1 != 5'd0 && ent_rd == q1) || (q2 != 5'd0 && ent_rd == q2) ||
             (qd != 5'd0 && ent_rd == qd))
            e_hit = 1'b1;
      end

      @(negedge clk);
      obs_we    = reg_write;
      obs_rd    = rd;
      obs_data  = wb_data;
      obs_rdy   = lu_ready;
      obs_hit   = pend_hit;
      obs_stall = stall_req;
      chk("reg_write", 32'(obs_we), 32'(e_we));
      chk("rd", 32'(obs_rd), 32'(e_rd));
      chk("wb_data", obs_data, e_data);
      chk("lu_ready", 32'(obs_rdy), 32'(e_rdy));
      chk("pend_hit", 32'(obs_hit), 32'(e_hit));
      chk("stall_req", 32'(obs_stall), 32'(e_stall));

      if (exp_q.size() > 0 && !drain) begin
         if (starve_m < LIMIT) starve_m++;
      end else begin
         starve_m = 0;
      end
      if (drain) void'(exp_q.pop_front());
      if (lv && e_rdy && lrd != 5'd0 && !byp) exp_q.push_back({lrd, ldata});

      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycle();
      cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
   endtask

   initial begin
      tests    = 0;
      fails    = 0;
      starve_m = 0;

      // ---- reset held: outputs gated even with active requests ----
      set_idle();
      pipe_reg_write = 1'b1;
      pipe_rd        = 5'd3;
      lu_valid       = 1'b1;
      lu_rd          = 5'd4;
      query_rs1      = 5'd4;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_reg_write", 32'(reg_write), 32'd0);
      chk("rst_lu_ready", 32'(lu_ready), 32'd0);
      chk("rst_pend_hit", 32'(pend_hit), 32'd0);
      chk("rst_stall", 32'(stall_req), 32'd0);
      set_idle();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // ---- vector table ----
      vecs[0] = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 5'd0, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0};
      vecs[1] = '{1'b0, 5'd0,  32'h0,    1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0};
      vecs[2] = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 32'h0,        5'd5, 5'd0, 5'd0, 1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 1'b1};
      vecs[3] = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 32'h0,        5'd5, 5'd0, 5'd0, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0};
      vecs[4] = '{1'b1, 5'd10, 32'h1111, 1'b1, 5'd7, 32'h77,       5'd0, 5'd0, 5'd0, 1'b1, 5'd10, 32'h1111,     1'b1, 1'b0};
      vecs[5] = '{1'b1, 5'd11, 32'h2222, 1'b0, 5'd0, 32'h0,        5'd0, 5'd7, 5'd0, 1'b1, 5'd11, 32'h2222,     1'b1, 1'b1};
      vecs[6] = '{1'b1, 5'd0,  32'h1,    1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 5'd7, 1'b1, 5'd7,  32'h77,       1'b1, 1'b1};
      vecs[7] = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 32'h0,        5'd0, 5'd7, 5'd0, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0};
      vecs[8] = '{1'b0, 5'd0,  32'h0,    1'b1, 5'd0, 32'h99,       5'd0, 5'd0, 5'd0, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0};
      vecs[9] = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 5'd0, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0};

      for (int v = 0; v < 10; v++) begin
         cycle(vecs[v].pwe, vecs[v].prd, vecs[v].pdata, vecs[v].lv, vecs[v].lrd, vecs[v].ldata,
               vecs[v].q1, vecs[v].q2, vecs[v].qd);
`ifndef RV32_WB_ARB_BYPASS_EN
         chk($sformatf("vec%0d_we", v), 32'(obs_we), 32'(vecs[v].e_we));
         chk($sformatf("vec%0d_rd", v), 32'(obs_rd), 32'(vecs[v].e_rd));
         chk($sformatf("vec%0d_data", v), obs_data, vecs[v].e_data);
         chk($sformatf("vec%0d_ready", v), 32'(obs_rdy), 32'(vecs[v].e_rdy));
         chk($sformatf("vec%0d_hit", v), 32'(obs_hit), 32'(vecs[v].e_hit));
`endif
      end

      // ---- starvation, full FIFO, drain ordering ----
      for (int c = 0; c < 4; c++)
         cycle(1'b1, 5'(20 + c), 32'h1000 + 32'(c), 1'b1, 5'(12 + c), 32'hA000_0000 + 32'(c),
               5'd0, 5'd0, 5'd0);
      for (int c = 4; c < 10; c++) begin
         cycle(1'b1, 5'd24, 32'h2000 + 32'(c), 1'b1, 5'd16, 32'hA000_0004, 5'd0, 5'd0, 5'd0);
         if (c == 4) chk("full_ready", 32'(obs_rdy), 32'd0);
         if (c == 8) chk("stall_before_limit", 32'(obs_stall), 32'd0);
         if (c == 9) chk("stall_at_limit", 32'(obs_stall), 32'd1);
      end
      // Bubble: head drains; full FIFO still refuses the waiting result.
      cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd16, 32'hA000_0004, 5'd0, 5'd0, 5'd0);
      chk("bubble_rd", 32'(obs_rd), 32'd12);
      chk("bubble_data", obs_data, 32'hA000_0000);
      chk("bubble_stall_held", 32'(obs_stall), 32'd1);
      chk("bubble_ready", 32'(obs_rdy), 32'd0);
      cycle(1'b1, 5'd25, 32'h3000, 1'b1, 5'd16, 32'hA000_0004, 5'd0, 5'd0, 5'd0);
      chk("after_bubble_stall", 32'(obs_stall), 32'd0);
      chk("after_bubble_ready", 32'(obs_rdy), 32'd1);
      for (int c = 0; c < 4; c++) begin
         idle_cycle();
         if (c == 3) begin
            chk("fifth_rd", 32'(obs_rd), 32'd16);
            chk("fifth_data", obs_data, 32'hA000_0004);
         end
      end
      idle_cycle();
      chk("drained_idle", 32'(obs_we), 32'd0);

      // ---- reset mid-operation with 3 queued entries ----
      for (int c = 0; c < 3; c++)
         cycle(1'b1, 5'd9, 32'h4000 + 32'(c), 1'b1, 5'(3 + c), 32'hB000_0000 + 32'(c),
               5'd0, 5'd0, 5'd0);
      pipe_reg_write = 1'b1;
      pipe_rd        = 5'd9;
      lu_valid       = 1'b0;
      query_rs1      = 5'd3;
      #1;
      chk("pre_rst_hit", 32'(pend_hit), 32'd1);
      #1;
      rst = 1'b1;
      #1;
      chk("mid_rst_reg_write", 32'(reg_write), 32'd0);
      chk("mid_rst_ready", 32'(lu_ready), 32'd0);
      chk("mid_rst_hit", 32'(pend_hit), 32'd0);
      exp_q.delete();
      starve_m = 0;
      set_idle();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      for (int c = 0; c < 4; c++) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd4, 5'd5);

      // ---- random traffic ----
      for (int c = 0; c < 300; c++) begin
         cycle(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom,
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
               5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      end
      for (int c = 0; c < 6; c++) idle_cycle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
